inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage of the multi-cycle core; sits directly downstream of the PC register.
//  On a fetch_start pulse from the main controller it samples PC, checks alignment and runs a
//  req/gnt + rvalid transaction on the instruction-memory port.
//  It loads IR and pc_of_ir, then pulses fetch_done so the controller can advance (decode, PC_we).
// PARAMETERS
//  RESET_PC  32'h1c00_0000  value of pc_of_ir after reset (matches PC reset vector)
//  NOP_INST  32'h0340_0000  LoongArch nop (andi r0,r0,0); IR reset/error fill value
//  TIMEOUT   255            max cycles waiting for rvalid after grant; 0 = timeout disabled
// PORTS
//  clk          in   1   core clock, rising edge
//  rstn         in   1   asynchronous, active-low reset
//  pc           in   32  current PC from PC register
//  fetch_start  in   1   1-cycle request from controller; ignored unless state==IDLE
//  flush        in   1   abort current fetch (exception/redirect)
//  imem_req     out  1   memory request valid
//  imem_addr    out  32  word address = latched pc
//  imem_gnt     in   1   memory accepted request (req&&gnt = handshake)
//  imem_rvalid  in   1   read data valid; never same cycle as its gnt
//  imem_rdata   in   32  instruction word
//  imem_err     in   1   bus error, qualified by imem_rvalid
//  ir           out  32  instruction register
//  pc_of_ir     out  32  PC of instruction held in ir
//  fetch_done   out  1   1-cycle pulse: ir/pc_of_ir updated and valid
//  adef         out  1   1-cycle pulse: misaligned fetch (pc[1:0]!=0), with fetch_done
//  bus_err      out  1   1-cycle pulse: imem_err or timeout, with fetch_done
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, ir=NOP_INST, pc_of_ir=RESET_PC, all 1-bit outputs 0, imem_addr=0,
//   timeout count 0. Reset mid-transaction drops it; imem is reset by the same rstn.
//  States IDLE, REQ, WAIT, DONE, DRAIN.
//  IDLE: fetch_start -> latch pc into addr_q.
//   pc[1:0]!=0 -> DONE with adef=1, ir=NOP_INST, no memory request; else -> REQ.
//  REQ: imem_req=1, imem_addr=addr_q held stable until gnt; req&&gnt -> WAIT, count cleared.
//  WAIT: rvalid -> ir=imem_err?NOP_INST:imem_rdata, pc_of_ir=addr_q, bus_err=imem_err, -> DONE.
//   Count increments each cycle without rvalid; count==TIMEOUT-1 -> ir=NOP_INST, bus_err, -> DRAIN.
//  DONE: fetch_done=1 (adef/bus_err asserted this cycle too) -> IDLE; min latency start->done
//   with 1-cycle gnt and rvalid = 4 cycles.
//  DRAIN: swallow exactly one rvalid (no ir update) -> IDLE. After a timeout, fetch_done
//   pulses in the first DRAIN cycle.
//  flush: REQ -> IDLE (req dropped same cycle, no handshake);
//   WAIT -> DRAIN; flush+rvalid same cycle in WAIT -> IDLE, no update.
//   In DONE, flush suppresses fetch_done/adef/bus_err, but ir stays written.
//   In IDLE/DRAIN, flush has no effect.
//  fetch_start while busy: ignored, no queuing. flush has priority over fetch_start.
//  ir/pc_of_ir change only on completed or faulted fetches; stable otherwise.
// STRUCTURE
//  cpu_pkg: typedef enum logic[2:0] if_state_t; localparams RESET_PC, NOP_INST shared with PC/decode.
//  Sub-module if_timeout_cnt (clear/inc/expire, width $clog2(TIMEOUT+1)); rest is one FSM + regs.
// TESTING
//  pc=1c00_0000, start; gnt next cycle; rvalid rdata=0280_0421 one cycle later ->
//   ir=0280_0421, pc_of_ir=1c00_0000, fetch_done 1 cycle, total 4 cycles.
//  gnt held low 5 cycles -> imem_req/addr stable all 5 cycles; single handshake; correct ir.
//  pc=1c00_0002, start -> no imem_req; fetch_done+adef pulse in cycle 2; ir=0340_0000.
//  rvalid with imem_err=1 -> bus_err+fetch_done; ir=0340_0000.
//   TIMEOUT=4, no rvalid -> bus_err after 4 WAIT cycles; late rvalid drained, ir unchanged.
//  flush in WAIT, rvalid 2 cycles later -> no fetch_done, ir unchanged, busy low after rvalid.
//   fetch_start during WAIT is ignored.
//  rstn low in WAIT -> outputs reset immediately (async); next start fetches normally.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and the fetch-stage state type for the multi-cycle core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_pkg;

  // Both constants are shared with the PC register and the decode stage.
  localparam logic [31:0] CPU_RESET_PC = 32'h1c00_0000;
  localparam logic [31:0] CPU_NOP_INST = 32'h0340_0000;  // andi r0,r0,0

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } if_state_t;

  // Instruction fetches must be word aligned.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory port: request/grant address phase, then a single rvalid response.
// Latency: n/a (wires only).
// Backpressure: memory stalls the request by holding gnt low; rvalid never shares a cycle with its gnt.
//  req    master->slave  request valid, addr held stable until gnt
//  addr   master->slave  32-bit word address
//  gnt    slave->master  request accepted (req && gnt is the handshake)
//  rvalid slave->master  response valid
//  rdata  slave->master  instruction word
//  err    slave->master  bus error, qualified by rvalid
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/inst_fetch_timeout_cnt.sv
// Counts cycles spent waiting for a memory response and flags the last allowed one.
// Latency: expire is combinational from the registered count.
// Backpressure: none; clr has priority over inc. TIMEOUT=0 disables expiry.
//  clk, rstn  clock / async active-low reset
//  clr        zero the count
//  inc        advance the count by one
//  expire     count has reached TIMEOUT-1
module if_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: samples PC on fetch_start, runs one imem transaction, loads ir/pc_of_ir.
// Latency: 4 cycles start->fetch_done with 1-cycle gnt and rvalid; 2 cycles for a misaligned PC.
// Backpressure: holds req/addr until gnt; waits up to TIMEOUT cycles for rvalid; fetch_start ignored while busy.
//  clk, rstn       clock / async active-low reset
//  pc, fetch_start PC register value and 1-cycle start pulse from the controller
//  flush           abort the fetch in flight (exception / redirect)
//  imem            instruction-memory master port
//  ir, pc_of_ir    fetched instruction and its address
//  fetch_done      1-cycle pulse, ir/pc_of_ir valid; adef/bus_err qualify it
//  busy            fetch in progress
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  pc,
  input  logic         fetch_start,
  input  logic         flush,
  inst_fetch_if.master imem,
  output logic [31:0]  ir,
  output logic [31:0]  pc_of_ir,
  output logic         fetch_done,
  output logic         adef,
  output logic         bus_err,
  output logic         busy
);

  if_state_t   state_q, state_d;
  logic [31:0] addr_q;
  logic        adef_q, berr_q;
  logic        tmo_q;        // first DRAIN cycle after a timeout: report the fault then
  logic        latch_pc, ev_adef, ev_rsp, ev_tmo;
  logic        tmo_expire;

  if_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (state_q != S_WAIT),
    .inc    ((state_q == S_WAIT) && !imem.rvalid),
    .expire (tmo_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath load events
  always_comb begin
    state_d  = state_q;
    latch_pc = 1'b0;
    ev_adef  = 1'b0;
    ev_rsp   = 1'b0;
    ev_tmo   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_start && !flush) begin
          latch_pc = 1'b1;
          if (pc_misaligned(pc[1:0])) begin
            ev_adef = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (imem.gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flushed fetch still owes one response; drain it unless it is arriving now.
        if (flush) begin
          state_d = imem.rvalid ? S_IDLE : S_DRAIN;
        end else if (imem.rvalid) begin
          ev_rsp  = 1'b1;
          state_d = S_DONE;
        end else if (tmo_expire) begin
          ev_tmo  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (imem.rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    imem.req   = (state_q == S_REQ) && !flush;
    fetch_done = ((state_q == S_DONE) && !flush) || ((state_q == S_DRAIN) && tmo_q);
    adef       = fetch_done && adef_q;
    bus_err    = fetch_done && berr_q;
    busy       = state_q != S_IDLE;
  end

  assign imem.addr = addr_q;

  // ir/pc_of_ir only move on a completed or faulted fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      ir       <= NOP_INST;
      pc_of_ir <= RESET_PC;
      adef_q   <= 1'b0;
      berr_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= ev_tmo;
      if (latch_pc) begin
        addr_q <= pc;
      end
      if (ev_adef) begin
        ir       <= NOP_INST;
        pc_of_ir <= pc;
        adef_q   <= 1'b1;
        berr_q   <= 1'b0;
      end
      if (ev_rsp) begin
        ir       <= imem.err ? NOP_INST : imem.rdata;
        pc_of_ir <= addr_q;
        adef_q   <= 1'b0;
        berr_q   <= imem.err;
      end
      if (ev_tmo) begin
        ir       <= NOP_INST;
        pc_of_ir <= addr_q;
        adef_q   <= 1'b0;
        berr_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: table of directed fetches plus hand-written flush/timeout/reset sequences.
// Latency: n/a.
// Backpressure: memory model stalls gnt and rvalid per vector.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;
  localparam logic [31:0] NOP    = 32'h0340_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] pc;
  logic        fetch_start;
  logic        flush;
  logic [31:0] ir;
  logic [31:0] pc_of_ir;
  logic        fetch_done;
  logic        adef;
  logic        bus_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_if imem_bus();

  inst_fetch #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pc          (pc),
    .fetch_start (fetch_start),
    .flush       (flush),
    .imem        (imem_bus),
    .ir          (ir),
    .pc_of_ir    (pc_of_ir),
    .fetch_done  (fetch_done),
    .adef        (adef),
    .bus_err     (bus_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    int          gnt_dly;   // cycles req is held before gnt
    int          rv_dly;    // cycles after gnt until rvalid
    logic [31:0] rdata;
    bit          err;
    logic [31:0] exp_ir;
    logic [31:0] exp_pcir;
    bit          exp_adef;
    bit          exp_berr;
    int          exp_lat;   // start cycle = 1, fetch_done cycle = exp_lat
    int          exp_hs;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit fl, input bit g, input bit rv, input logic [31:0] rd);
    @(posedge clk); #1;
    fetch_start      = st;
    flush            = fl;
    imem_bus.gnt     = g;
    imem_bus.rvalid  = rv;
    imem_bus.rdata   = rd;
    imem_bus.err     = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    int          cyc, gcnt, rcnt, hs, lat, addr_bad, spur;
    bit          granted, rv_sent, adef_s, berr_s;
    logic [31:0] ir_s, pcir_s;
    v = vecs[idx];
    gcnt = 0; rcnt = 0; hs = 0; lat = 0; addr_bad = 0; spur = 0;
    granted = 0; rv_sent = 0; adef_s = 0; berr_s = 0; ir_s = '0; pcir_s = '0;
    @(posedge clk); #1;
    pc = v.pc; fetch_start = 1'b1; flush = 1'b0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.err = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (lat == 0 && cyc < 40) begin
      @(posedge clk); #1;
      fetch_start = 1'b0; imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.err = 1'b0;
      cyc++;
      if (imem_bus.req) begin
        if (imem_bus.addr !== v.pc) addr_bad++;
        if (granted) begin
          hs++;
        end else if (gcnt == v.gnt_dly) begin
          imem_bus.gnt = 1'b1; granted = 1; hs++;
        end else begin
          gcnt++;
        end
      end else if (granted && !rv_sent) begin
        rcnt++;
        if (rcnt == v.rv_dly) begin
          imem_bus.rvalid = 1'b1; imem_bus.rdata = v.rdata; imem_bus.err = v.err; rv_sent = 1;
        end
      end
      @(negedge clk);
      if (fetch_done) begin
        lat = cyc; ir_s = ir; pcir_s = pc_of_ir; adef_s = adef; berr_s = bus_err;
      end else if (adef || bus_err) begin
        spur++;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_ir", idx), ir_s, v.exp_ir);
    chk($sformatf("v%0d_pc_of_ir", idx), pcir_s, v.exp_pcir);
    chk($sformatf("v%0d_adef", idx), {31'd0, adef_s}, {31'd0, v.exp_adef});
    chk($sformatf("v%0d_bus_err", idx), {31'd0, berr_s}, {31'd0, v.exp_berr});
    chk($sformatf("v%0d_handshakes", idx), hs, v.exp_hs);
    chk($sformatf("v%0d_addr_stable", idx), addr_bad, 0);
    chk($sformatf("v%0d_spurious_flag", idx), spur, 0);
    drive(0, 0, 0, 0, '0);
    chk($sformatf("v%0d_done_one_cycle", idx), {31'd0, fetch_done}, 32'd0);
    chk($sformatf("v%0d_idle_after", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen_done;

    //         pc            gnt rv  rdata         err exp_ir        exp_pcir      adf ber lat hs
    vecs[0] = '{32'h1c00_0000, 0, 1, 32'h0280_0421, 0, 32'h0280_0421, 32'h1c00_0000, 0, 0, 4, 1};
    vecs[1] = '{32'h1c00_0004, 5, 1, 32'h1234_5678, 0, 32'h1234_5678, 32'h1c00_0004, 0, 0, 9, 1};
    vecs[2] = '{32'h1c00_0002, 0, 1, 32'hffff_ffff, 0, NOP,           32'h1c00_0002, 1, 0, 2, 0};
    vecs[3] = '{32'h1c00_0008, 0, 1, 32'hdead_beef, 1, NOP,           32'h1c00_0008, 0, 1, 4, 1};
    vecs[4] = '{32'h1c00_000c, 2, 4, 32'h0015_0c20, 0, 32'h0015_0c20, 32'h1c00_000c, 0, 0, 9, 1};
    vecs[5] = '{32'h1c00_0001, 0, 1, 32'h0000_0000, 0, NOP,           32'h1c00_0001, 1, 0, 2, 0};
    vecs[6] = '{32'h1c00_0013, 3, 2, 32'h0000_0000, 0, NOP,           32'h1c00_0013, 1, 0, 2, 0};

    rstn = 1'b0; pc = '0; fetch_start = 1'b0; flush = 1'b0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0; imem_bus.err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir", ir, NOP);
    chk("rst_pc_of_ir", pc_of_ir, RST_PC);
    chk("rst_req", {31'd0, imem_bus.req}, 32'd0);
    chk("rst_addr", imem_bus.addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_adef", {31'd0, adef}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Flush in DONE: pulse suppressed, ir still written.
    pc = 32'h1c00_0040;
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0);
    drive(0, 0, 0, 1, 32'haabb_ccdd);
    drive(0, 1, 0, 0, '0);
    chk("flush_done_no_pulse", {31'd0, fetch_done}, 32'd0);
    drive(0, 0, 0, 0, '0);
    chk("flush_done_ir", ir, 32'haabb_ccdd);
    chk("flush_done_pc_of_ir", pc_of_ir, 32'h1c00_0040);
    chk("flush_done_idle", {31'd0, busy}, 32'd0);

    // Async reset while waiting for rvalid.
    pc = 32'h1c00_0060;
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0);
    drive(0, 0, 0, 0, '0);
    #1 rstn = 1'b0;
    #1;
    chk("arst_ir", ir, NOP);
    chk("arst_pc_of_ir", pc_of_ir, RST_PC);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", imem_bus.addr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_vec(0);

    // Flush in WAIT, response two cycles later is drained; fetch_start in WAIT ignored.
    seen_done = 0;
    pc = 32'h1c00_0020;
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0);
    seen_done += fetch_done;
    drive(1, 0, 0, 0, '0);
    seen_done += fetch_done;
    drive(0, 1, 0, 0, '0);
    seen_done += fetch_done;
    drive(0, 0, 0, 0, '0);
    seen_done += fetch_done;
    chk("flush_wait_busy_drain", {31'd0, busy}, 32'd1);
    drive(0, 0, 0, 1, 32'h5555_5555);
    seen_done += fetch_done;
    chk("flush_wait_busy_rvalid", {31'd0, busy}, 32'd1);
    drive(0, 0, 0, 0, '0);
    seen_done += fetch_done;
    chk("flush_wait_idle", {31'd0, busy}, 32'd0);
    chk("flush_wait_ir", ir, 32'h0280_0421);
    chk("flush_wait_pc_of_ir", pc_of_ir, 32'h1c00_0000);
    drive(0, 0, 0, 0, '0);
    seen_done += fetch_done;
    chk("start_in_wait_not_queued", {31'd0, busy}, 32'd0);
    chk("flush_wait_no_done", seen_done, 0);

    // Timeout (TIMEOUT=4): four WAIT cycles, fault reported in first DRAIN cycle, late rvalid swallowed.
    seen_done = 0;
    pc = 32'h1c00_0010;
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, '0);
      seen_done += fetch_done;
    end
    chk("tmo_no_early_done", seen_done, 0);
    drive(0, 0, 0, 0, '0);
    chk("tmo_fetch_done", {31'd0, fetch_done}, 32'd1);
    chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    chk("tmo_ir", ir, NOP);
    chk("tmo_pc_of_ir", pc_of_ir, 32'h1c00_0010);
    drive(0, 0, 0, 0, '0);
    chk("tmo_done_one_cycle", {31'd0, fetch_done}, 32'd0);
    chk("tmo_drain_busy", {31'd0, busy}, 32'd1);
    drive(0, 0, 0, 1, 32'h1111_1111);
    chk("tmo_late_rvalid_no_done", {31'd0, fetch_done}, 32'd0);
    drive(0, 0, 0, 0, '0);
    chk("tmo_drained_idle", {31'd0, busy}, 32'd0);
    chk("tmo_late_ir_unchanged", ir, NOP);

    // Flush in REQ: request dropped in the same cycle, no handshake.
    pc = 32'h1c00_0050;
    drive(1, 0, 0, 0, '0);
    chk("req_before_flush", {31'd0, imem_bus.req}, 32'd0);
    drive(0, 1, 1, 0, '0);
    chk("flush_req_dropped", {31'd0, imem_bus.req}, 32'd0);
    drive(0, 0, 0, 0, '0);
    chk("flush_req_idle", {31'd0, busy}, 32'd0);
    chk("flush_req_pc_of_ir", pc_of_ir, 32'h1c00_0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
